// File: rtl/phy_pkg.sv
// Shared constants for the PHY receive path: word geometry, FSM encoding and
// the byte-lane placement helper used by the word assembler.
package phy_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Bit offset of byte k inside a word, for either arrival order.
  function automatic int lane_lsb(input int k, input bit msb_first);
    if (msb_first) begin
      return WORD_W - BYTE_W * (k + 1);
    end
    return BYTE_W * k;
  endfunction

endpackage

// File: rtl/phy_rx_word_assembler_if.sv
// Byte-in / word-out bundle of the receive word assembler. The master side
// feeds bytes and counter clears; the slave side returns words and status.
interface phy_rx_word_assembler_if
  import phy_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              valid_in;
  logic [BYTE_W-1:0] data_in;
  logic              clear_cnt;
  logic              valid_out;
  logic [WORD_W-1:0] data_out;
  logic              err_partial;
  logic [CNT_W-1:0]  word_count;
  logic              busy;

  modport master (
    output valid_in, data_in, clear_cnt,
    input  valid_out, data_out, err_partial, word_count, busy
  );

  modport slave (
    input  valid_in, data_in, clear_cnt,
    output valid_out, data_out, err_partial, word_count, busy
  );

endinterface

// File: rtl/phy_rx_word_assembler.sv
// Rebuilds 32-bit words from the received byte stream, flags words cut short
// by a valid gap and keeps a saturating count of delivered words.
module phy_rx_word_assembler
  import phy_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  phy_rx_word_assembler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [WORD_W-1:0] w_word;
  logic              w_last;

  // Current byte merged into its slot so the 4th byte can be emitted directly.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      localparam int LSB = lane_lsb(gi, MSB_FIRST);
      assign w_word[LSB +: BYTE_W] = (r_idx == IDX_W'(gi)) ? bus.data_in
                                                            : r_shift[LSB +: BYTE_W];
    end
  endgenerate

  assign w_last = bus.valid_in && (r_idx == IDX_LAST);

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (bus.valid_in) begin
        if (w_last) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
          r_idx   <= '0;
          r_shift <= '0;
          r_state <= ST_IDLE;
        end else begin
          r_shift <= w_word;
          r_idx   <= r_idx + 1'b1;
          r_state <= ST_COLLECT;
        end
      end else if (r_state == ST_COLLECT) begin
        r_err   <= 1'b1;
        r_idx   <= '0;
        r_shift <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  // Counted at the completing edge so word_count moves together with valid_out.
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (bus.clear_cnt) begin
      r_cnt <= '0;
    end else if (w_last && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.valid_out   = r_valid;
  assign bus.data_out    = r_data;
  assign bus.err_partial = r_err;
  assign bus.word_count  = r_cnt;
  assign bus.busy        = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_phy_rx_word_assembler.sv
// Drives one byte stream into three assembler variants (MSB-first/16-bit count,
// MSB-first/2-bit count, LSB-first/16-bit count) and checks them against a queue model.
module tb_phy_rx_word_assembler;

  logic clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  logic       reset_L;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic       tb_clr;

  phy_rx_word_assembler_if #(.CNT_W(16)) bus0();
  phy_rx_word_assembler_if #(.CNT_W(2))  bus1();
  phy_rx_word_assembler_if #(.CNT_W(16)) bus2();

  assign bus0.valid_in  = tb_valid;
  assign bus0.data_in   = tb_data;
  assign bus0.clear_cnt = tb_clr;
  assign bus1.valid_in  = tb_valid;
  assign bus1.data_in   = tb_data;
  assign bus1.clear_cnt = tb_clr;
  assign bus2.valid_in  = tb_valid;
  assign bus2.data_in   = tb_data;
  assign bus2.clear_cnt = tb_clr;

  phy_rx_word_assembler #(.MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(bus0));
  phy_rx_word_assembler #(.MSB_FIRST(1'b1), .CNT_W(2)) dut1 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(bus1));
  phy_rx_word_assembler #(.MSB_FIRST(1'b0), .CNT_W(16)) dut2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(bus2));

  logic        o_valid[3];
  logic        o_err[3];
  logic        o_busy[3];
  logic [31:0] o_data[3];
  logic [31:0] o_cnt[3];

  assign o_valid[0] = bus0.valid_out;
  assign o_valid[1] = bus1.valid_out;
  assign o_valid[2] = bus2.valid_out;
  assign o_err[0]   = bus0.err_partial;
  assign o_err[1]   = bus1.err_partial;
  assign o_err[2]   = bus2.err_partial;
  assign o_busy[0]  = bus0.busy;
  assign o_busy[1]  = bus1.busy;
  assign o_busy[2]  = bus2.busy;
  assign o_data[0]  = bus0.data_out;
  assign o_data[1]  = bus1.data_out;
  assign o_data[2]  = bus2.data_out;
  assign o_cnt[0]   = 32'(bus0.word_count);
  assign o_cnt[1]   = 32'(bus1.word_count);
  assign o_cnt[2]   = 32'(bus2.word_count);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes of the word in progress, plus expected outputs.
  bit          msb[3]  = '{1'b1, 1'b1, 1'b0};
  int          cmax[3] = '{65535, 3, 65535};
  logic [7:0]  q[$];
  logic        m_valid;
  logic        m_err;
  logic        m_busy;
  logic [31:0] m_data[3];
  int          m_cnt[3];

  task automatic tick(input logic rst_n, input logic v, input logic [7:0] d, input logic c);
    logic [31:0] w;
    reset_L  = rst_n;
    tb_valid = v;
    tb_data  = d;
    tb_clr   = c;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin
        m_data[i] = 32'h0;
        m_cnt[i]  = 0;
      end
    end else begin
      if (v) begin
        q.push_back(d);
        if (q.size() == 4) begin
          for (int i = 0; i < 3; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
              if (msb[i]) w = (w << 8) | 32'(q[k]);
              else        w = w | (32'(q[k]) << (8 * k));
            end
            m_data[i] = w;
          end
          m_valid = 1'b1;
          q.delete();
        end
      end else if (q.size() != 0) begin
        m_err = 1'b1;
        q.delete();
      end
      for (int i = 0; i < 3; i++) begin
        if (c) m_cnt[i] = 0;
        else if (m_valid && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_busy = (q.size() != 0);
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({o_valid[i], o_err[i], o_busy[i]} !== 3'b000 || o_data[i] !== 32'h0 || o_cnt[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: valid=%b err=%b busy=%b data=%h cnt=%0d, want all 0",
                 i, o_valid[i], o_err[i], o_busy[i], o_data[i], o_cnt[i]);
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, b[k], 1'b0);
    n_tests++;
    if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_early: valid=%b busy=%b, want valid=0 busy=1", o_valid[0], o_busy[0]);
    end
    tick(1'b1, 1'b1, b[3], 1'b0);
    n_tests++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 32'hAABBCCDD || o_cnt[0] !== 32'd1 || o_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_msb: valid=%b data=%h cnt=%0d busy=%b, want 1 AABBCCDD 1 0",
               o_valid[0], o_data[0], o_cnt[0], o_busy[0]);
    end
    n_tests++;
    if (o_valid[2] !== 1'b1 || o_data[2] !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL single_lsb: valid=%b data=%h, want 1 DDCCBBAA", o_valid[2], o_data[2]);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if (o_valid[0] !== 1'b0 || o_data[0] !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b data=%h, want 0 AABBCCDD", o_valid[0], o_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1, 8'(k), 1'b0);
      n_tests++;
      if (o_valid[0] !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL b2b_pulse byte%0d: valid=%b want %b", k, o_valid[0], (k % 4 == 0));
      end
      if (k == 4 || k == 8) begin
        n_tests++;
        if (o_data[0] !== (k == 4 ? 32'h01020304 : 32'h05060708)) begin
          n_fail++;
          $display("FAIL b2b_data byte%0d: data=%h", k, o_data[0]);
        end
      end
    end
    n_tests++;
    if (o_cnt[0] !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_count: cnt=%0d want 2", o_cnt[0]);
    end
  endtask

  task automatic test_partial();
    logic [7:0] b[4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] w0[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, w0[k], 1'b0);
    tick(1'b1, 1'b1, 8'h11, 1'b0);
    tick(1'b1, 1'b1, 8'h22, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if (o_err[0] !== 1'b1 || o_valid[0] !== 1'b0 || o_data[0] !== 32'hA1B2C3D4 ||
        o_cnt[0] !== 32'd1 || o_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_err: err=%b valid=%b data=%h cnt=%0d busy=%b, want 1 0 A1B2C3D4 1 0",
               o_err[0], o_valid[0], o_data[0], o_cnt[0], o_busy[0]);
    end
    tick(1'b1, 1'b1, b[0], 1'b0);
    n_tests++;
    if (o_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_err_width: err=%b want 0", o_err[0]);
    end
    for (int k = 1; k < 4; k++) tick(1'b1, 1'b1, b[k], 1'b0);
    n_tests++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 32'h33445566 || o_cnt[0] !== 32'd2) begin
      n_fail++;
      $display("FAIL partial_next: valid=%b data=%h cnt=%0d, want 1 33445566 2",
               o_valid[0], o_data[0], o_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] b[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tick(1'b1, 1'b1, 8'h01, 1'b0);
    tick(1'b1, 1'b1, 8'h02, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++;
    if (o_err[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_cnt[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: err=%b busy=%b cnt=%0d, want 0 0 0", o_err[0], o_busy[0], o_cnt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, b[k], 1'b0);
      n_tests++;
      if (o_err[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_noerr byte%0d: err=%b want 0", k, o_err[0]);
      end
    end
    n_tests++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rst_mid_word: valid=%b data=%h, want 1 DEADBEEF", o_valid[0], o_data[0]);
    end
  endtask

  task automatic test_saturation();
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int w = 1; w <= 5; w++) begin
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 8'($urandom), 1'b0);
      n_tests++;
      if (o_cnt[1] !== 32'(w < 3 ? w : 3) || o_cnt[0] !== 32'(w)) begin
        n_fail++;
        $display("FAIL sat_count word%0d: cnt2bit=%0d want %0d, cnt16=%0d want %0d",
                 w, o_cnt[1], (w < 3 ? w : 3), o_cnt[0], w);
      end
    end
  endtask

  task automatic test_clear_collision();
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 8'(k + 16), 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 8'(k + 32), 1'b0);
    tick(1'b1, 1'b1, 8'h23, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (o_valid[i] !== 1'b1 || o_cnt[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL clear_vs_incr dut%0d: valid=%b cnt=%0d, want 1 0", i, o_valid[i], o_cnt[i]);
      end
    end
    n_tests++;
    if (o_data[0] !== 32'h20212223) begin
      n_fail++;
      $display("FAIL clear_word: data=%h want 20212223", o_data[0]);
    end
  endtask

  task automatic test_random();
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 600; c++) begin
      tick(($urandom_range(63) != 0), ($urandom_range(7) != 0), 8'($urandom),
           ($urandom_range(31) == 0));
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (o_valid[i] !== m_valid || o_err[i] !== m_err || o_busy[i] !== m_busy ||
            o_data[i] !== m_data[i] || o_cnt[i] !== 32'(m_cnt[i])) begin
          n_fail++;
          $display("FAIL random cyc%0d dut%0d: v/e/b=%b%b%b data=%h cnt=%0d, want %b%b%b %h %0d",
                   c, i, o_valid[i], o_err[i], o_busy[i], o_data[i], o_cnt[i],
                   m_valid, m_err, m_busy, m_data[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    tb_valid = 1'b0;
    tb_data  = 8'h00;
    tb_clr   = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_reset_mid_word();
    test_saturation();
    test_clear_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
